// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command master.
package wb_cmd_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUS     = 2'd1,
        ST_BACKOFF = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WB_RSP_OK  = 2'b00,
        WB_RSP_ERR = 2'b01,
        WB_RSP_RTY = 2'b10,
        WB_RSP_TMO = 2'b11
    } rsp_status_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone B3 classic single-cycle master: one bus cycle per command, with
// err/rty/timeout handling and a held response on a valid/ready port.
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int unsigned dw        = 32,
    parameter int unsigned aw        = 32,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned RETRY_GAP = 4
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [aw-1:0] cmd_adr_i,
    input  logic [dw-1:0] cmd_dat_i,
    input  logic [3:0]    cmd_sel_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [dw-1:0] rsp_dat_o,
    output logic [1:0]    rsp_status_o,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic [2:0]    wb_cti_o,
    output logic [1:0]    wb_bte_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    localparam int unsigned CW = $clog2(max_u(TIMEOUT, RETRY_GAP)) + 1;
    localparam int unsigned RW = $clog2(MAX_RETRY + 1) + 1;
    localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(RETRY_GAP - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry_cnt;

    assign wb_cti_o = WB_CTI_CLASSIC;
    assign wb_bte_o = WB_BTE_LINEAR;

    // cnt serves as the timeout counter in BUS and the gap counter in BACKOFF;
    // it is reloaded on every entry to either state.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            retry_cnt    <= '0;
            cmd_ready_o  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_dat_o    <= '0;
            rsp_status_o <= '0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_sel_o     <= '0;
            wb_we_o      <= 1'b0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_ready_o <= 1'b1;
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        wb_adr_o    <= cmd_adr_i;
                        wb_dat_o    <= cmd_dat_i;
                        wb_sel_o    <= cmd_sel_i;
                        wb_we_o     <= cmd_we_i;
                        wb_cyc_o    <= 1'b1;
                        wb_stb_o    <= 1'b1;
                        retry_cnt   <= '0;
                        cnt         <= TMO_LOAD;
                        state       <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (wb_err_i || wb_ack_i || wb_rty_i || cnt == '0) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                    end
                    if (wb_err_i) begin
                        rsp_valid_o  <= 1'b1;
                        rsp_status_o <= WB_RSP_ERR;
                        rsp_dat_o    <= '0;
                        state        <= ST_RESP;
                    end else if (wb_ack_i) begin
                        rsp_valid_o  <= 1'b1;
                        rsp_status_o <= WB_RSP_OK;
                        rsp_dat_o    <= wb_we_o ? '0 : wb_dat_i;
                        state        <= ST_RESP;
                    end else if (wb_rty_i) begin
                        if (retry_cnt < RW'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + RW'(1);
                            cnt       <= GAP_LOAD;
                            state     <= ST_BACKOFF;
                        end else begin
                            rsp_valid_o  <= 1'b1;
                            rsp_status_o <= WB_RSP_RTY;
                            rsp_dat_o    <= '0;
                            state        <= ST_RESP;
                        end
                    end else if (cnt == '0) begin
                        rsp_valid_o  <= 1'b1;
                        rsp_status_o <= WB_RSP_TMO;
                        rsp_dat_o    <= '0;
                        state        <= ST_RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_BACKOFF: begin
                    if (cnt == '0) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        cnt      <= TMO_LOAD;
                        state    <= ST_BUS;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master against a behavioural slave whose
// termination behaviour is selected per test.
module tb_wb_cmd_master;

    localparam int M_REG = 0, M_NONE = 1, M_RTY = 2, M_RTY1 = 3, M_ACKERR = 4;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_ready = 1'b0;
    logic        cmd_ready_o, rsp_valid_o;
    logic [31:0] rsp_dat_o;
    logic [1:0]  rsp_status_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;

    int passed = 0, total = 0;
    int mode = M_REG;
    logic rty_done = 1'b0;
    logic [31:0] mem [4];

    wb_cmd_master #(.dw(32), .aw(32), .TIMEOUT(16), .MAX_RETRY(3), .RETRY_GAP(4)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    always #5 wb_clk = ~wb_clk;

    // Slave with registered terminations, one cycle after stb.
    always @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            wb_ack_i <= 1'b0; wb_err_i <= 1'b0; wb_rty_i <= 1'b0; wb_dat_i <= '0;
        end else begin
            wb_ack_i <= 1'b0; wb_err_i <= 1'b0; wb_rty_i <= 1'b0;
            if (wb_cyc_o && wb_stb_o && !(wb_ack_i || wb_err_i || wb_rty_i)) begin
                case (mode)
                    M_REG, M_RTY1: begin
                        if (mode == M_RTY1 && !rty_done) begin
                            wb_rty_i <= 1'b1;
                            rty_done <= 1'b1;
                        end else begin
                            wb_ack_i <= 1'b1;
                            if (wb_we_o) begin
                                for (int b = 0; b < 4; b++)
                                    if (wb_sel_o[b]) mem[wb_adr_o[3:2]][8*b +: 8] <= wb_dat_o[8*b +: 8];
                            end else begin
                                wb_dat_i <= mem[wb_adr_o[3:2]];
                            end
                        end
                    end
                    M_RTY:    wb_rty_i <= 1'b1;
                    M_ACKERR: begin wb_ack_i <= 1'b1; wb_err_i <= 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    // Bus activity monitor: cycles high, pulse count, low gaps between pulses.
    int cyc_hi = 0, pulses = 0, low_run = 0, min_gap = 1000, max_gap = 0;
    logic prev_cyc = 1'b0;
    always @(negedge wb_clk) begin
        if (wb_cyc_o) cyc_hi++;
        if (wb_cyc_o && !prev_cyc) begin
            if (pulses > 0) begin
                if (low_run < min_gap) min_gap = low_run;
                if (low_run > max_gap) max_gap = low_run;
            end
            pulses++;
        end
        if (!wb_cyc_o) low_run++; else low_run = 0;
        prev_cyc = wb_cyc_o;
    end

    task automatic clear_mon();
        cyc_hi = 0; pulses = 0; low_run = 0; min_gap = 1000; max_gap = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_cmd(input string tag, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          input logic [31:0] exp_dat, input logic [1:0] exp_st,
                          input int exp_lat, input int hold);
        int n;
        int lat;
        @(negedge wb_clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        n = 0;
        while (!cmd_ready_o && n < 100) begin @(negedge wb_clk); n++; end
        if (!cmd_ready_o) begin
            check({tag, "_accept_timeout"}, 64'd0, 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge wb_clk); #1 cmd_valid = 1'b0;
        lat = -1;
        do begin @(negedge wb_clk); lat++; end while (!rsp_valid_o && lat < 200);
        if (!rsp_valid_o) begin
            check({tag, "_rsp_timeout"}, 64'd0, 64'd1);
            return;
        end
        check({tag, "_dat"}, 64'(rsp_dat_o), 64'(exp_dat));
        check({tag, "_status"}, 64'(rsp_status_o), 64'(exp_st));
        if (exp_lat >= 0) check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge wb_clk);
            check({tag, "_hold_valid"}, 64'(rsp_valid_o), 64'd1);
            check({tag, "_hold_dat"}, 64'(rsp_dat_o), 64'(exp_dat));
            check({tag, "_hold_status"}, 64'(rsp_status_o), 64'(exp_st));
            check({tag, "_hold_ready"}, 64'(cmd_ready_o), 64'd0);
            check({tag, "_hold_cyc"}, 64'(wb_cyc_o), 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge wb_clk); #1 rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, 64'(rsp_valid_o), 64'd0);
    endtask

    initial begin
        int bad;
        #3;
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
        check("rst_cyc", 64'(wb_cyc_o), 64'd0);
        check("rst_stb", 64'(wb_stb_o), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_status", 64'(rsp_status_o), 64'd0);
        check("cti_bte", 64'({wb_cti_o, wb_bte_o}), 64'd0);
        for (int i = 0; i < 4; i++) mem[i] = '0;
        repeat (2) @(negedge wb_clk);
        wb_rst = 1'b0;

        // Basic write / readback with latency.
        mode = M_REG;
        do_cmd("t1_wr", 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 2, 0);
        do_cmd("t1_rd", 1'b0, 32'h4, 32'h0, 4'hF, 32'hDEADBEEF, 2'b00, 2, 0);

        // Byte-lane write merge.
        do_cmd("t2_wr", 1'b1, 32'h0, 32'h11223344, 4'hF, 32'h0, 2'b00, 2, 0);
        do_cmd("t2_wrb", 1'b1, 32'h0, 32'h000000AA, 4'b0001, 32'h0, 2'b00, 2, 0);
        do_cmd("t2_rd", 1'b0, 32'h0, 32'h0, 4'hF, 32'h112233AA, 2'b00, 2, 0);

        // Timeout: cyc held exactly 16 cycles.
        mode = M_NONE; clear_mon();
        do_cmd("t3_tmo", 1'b0, 32'h8, 32'h0, 4'hF, 32'h0, 2'b11, 16, 0);
        check("t3_cyc_cycles", 64'(cyc_hi), 64'd16);

        // Retry exhausted: 4 attempts separated by 4 idle cycles.
        mode = M_RTY; clear_mon();
        do_cmd("t4_rty", 1'b0, 32'h4, 32'h0, 4'hF, 32'h0, 2'b10, -1, 0);
        check("t4_pulses", 64'(pulses), 64'd4);
        check("t4_min_gap", 64'(min_gap), 64'd4);
        check("t4_max_gap", 64'(max_gap), 64'd4);

        // Single retry then success.
        mode = M_RTY1; rty_done = 1'b0; clear_mon();
        do_cmd("t4_rty1", 1'b0, 32'h4, 32'h0, 4'hF, 32'hDEADBEEF, 2'b00, 8, 0);
        check("t4_rty1_pulses", 64'(pulses), 64'd2);
        check("t4_rty1_gap", 64'(min_gap), 64'd4);

        // err wins over ack.
        mode = M_ACKERR;
        do_cmd("t5_ackerr", 1'b0, 32'h4, 32'h0, 4'hF, 32'h0, 2'b01, 2, 0);

        // Response held while consumer stalls.
        mode = M_REG;
        do_cmd("t5_hold", 1'b0, 32'h0, 32'h0, 4'hF, 32'h112233AA, 2'b00, 2, 10);

        // Reset during BUS aborts without a response.
        mode = M_NONE;
        @(negedge wb_clk);
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'hC;
        bad = 0;
        while (!cmd_ready_o && bad < 100) begin @(negedge wb_clk); bad++; end
        @(posedge wb_clk); #1 cmd_valid = 1'b0;
        repeat (3) @(negedge wb_clk);
        check("t6_in_bus", 64'(wb_cyc_o), 64'd1);
        #2 wb_rst = 1'b1;
        #1;
        check("t6_cyc_async", 64'(wb_cyc_o), 64'd0);
        check("t6_stb_async", 64'(wb_stb_o), 64'd0);
        check("t6_ready_in_rst", 64'(cmd_ready_o), 64'd0);
        @(negedge wb_clk); wb_rst = 1'b0;
        @(posedge wb_clk); #1;
        check("t6_ready_after", 64'(cmd_ready_o), 64'd1);
        bad = 0;
        repeat (20) begin
            @(negedge wb_clk);
            if (rsp_valid_o || wb_cyc_o) bad++;
        end
        check("t6_no_rsp", 64'(bad), 64'd0);

        mode = M_REG;
        do_cmd("t6_post_rd", 1'b0, 32'h4, 32'h0, 4'hF, 32'hDEADBEEF, 2'b00, 2, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
